// File: rtl/seg_pipe_adder_if.sv
// Handshake and data bundle for the segmented pipelined adder.
// The master side supplies operands and accepts results; the slave side is the adder.
interface seg_pipe_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
  logic             sat_hit;

  modport master (
    output in_valid, a, b, cin, sat_en, out_ready,
    input  in_ready, out_valid, sum, sat_hit
  );

  modport slave (
    input  in_valid, a, b, cin, sat_en, out_ready,
    output in_ready, out_valid, sum, sat_hit
  );
endinterface

// File: rtl/seg_pipe_adder.sv
// Pipelined adder computing a + b + cin with the carry chain cut into SEG_W-bit segments,
// one segment resolved per register stage, with optional unsigned saturation.
// All stages advance together on a single enable, so a stalled output freezes the
// whole pipe and bubbles keep their position.
module seg_pipe_adder #(
  parameter int WIDTH = 8,
  parameter int SEG_W = 4
) (
  input logic             clk,
  input logic             rst_n,
  seg_pipe_adder_if.slave bus
);
  localparam int STAGES = (SEG_W > 0) ? WIDTH / SEG_W : 1;

  if (WIDTH < 1 || SEG_W < 1 || (WIDTH % SEG_W) != 0) begin : g_param_check
    $error("seg_pipe_adder: WIDTH must be a positive multiple of SEG_W");
  end

  logic adv;

  assign adv         = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // Stage k resolves bits [k*SEG_W +: SEG_W]; operand bits not yet added travel
  // along in a_hi/b_hi, already-resolved result bits accumulate in res.
  for (genvar k = 0; k < STAGES; k++) begin : stg
    localparam int DONE_W = (k + 1) * SEG_W;

    logic              v_prev;
    logic              c_prev;
    logic              s_prev;
    logic [SEG_W-1:0]  a_seg;
    logic [SEG_W-1:0]  b_seg;
    logic [SEG_W:0]    seg_sum;
    logic [DONE_W-1:0] res_next;
    logic              vld;

    if (k == 0) begin : g_src
      assign v_prev   = bus.in_valid;
      assign c_prev   = bus.cin;
      assign s_prev   = bus.sat_en;
      assign a_seg    = bus.a[SEG_W-1:0];
      assign b_seg    = bus.b[SEG_W-1:0];
      assign res_next = seg_sum[SEG_W-1:0];
    end else begin : g_src
      assign v_prev   = stg[k-1].vld;
      assign c_prev   = stg[k-1].g_reg.carry;
      assign s_prev   = stg[k-1].g_reg.sat;
      assign a_seg    = stg[k-1].g_reg.a_hi[SEG_W-1:0];
      assign b_seg    = stg[k-1].g_reg.b_hi[SEG_W-1:0];
      assign res_next = {seg_sum[SEG_W-1:0], stg[k-1].g_reg.res};
    end

    assign seg_sum = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_prev};

    // Valid bit follows its predecessor whenever the pipe advances.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
      end else if (adv) begin
        vld <= v_prev;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      localparam int HI_W = WIDTH - DONE_W;

      logic [DONE_W-1:0] res;
      logic              carry;
      logic              sat;
      logic [HI_W-1:0]   a_hi;
      logic [HI_W-1:0]   b_hi;
      logic [HI_W-1:0]   a_rest;
      logic [HI_W-1:0]   b_rest;

      if (k == 0) begin : g_rest
        assign a_rest = bus.a[WIDTH-1:SEG_W];
        assign b_rest = bus.b[WIDTH-1:SEG_W];
      end else begin : g_rest
        assign a_rest = stg[k-1].g_reg.a_hi[SEG_W +: HI_W];
        assign b_rest = stg[k-1].g_reg.b_hi[SEG_W +: HI_W];
      end

      // Data only loads for valid entries so bubbles never carry stray operand values.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          res   <= '0;
          carry <= 1'b0;
          sat   <= 1'b0;
          a_hi  <= '0;
          b_hi  <= '0;
        end else if (adv && v_prev) begin
          res   <= res_next;
          carry <= seg_sum[SEG_W];
          sat   <= s_prev;
          a_hi  <= a_rest;
          b_hi  <= b_rest;
        end
      end
    end else begin : g_out
      // Final stage applies saturation and holds the result until it is popped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          bus.sum     <= '0;
          bus.sat_hit <= 1'b0;
        end else if (adv && v_prev) begin
          if (s_prev && seg_sum[SEG_W]) begin
            bus.sum     <= {1'b0, {WIDTH{1'b1}}};
            bus.sat_hit <= 1'b1;
          end else begin
            bus.sum     <= {seg_sum[SEG_W], res_next};
            bus.sat_hit <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.out_valid = stg[STAGES-1].vld;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Directed self-checking bench for seg_pipe_adder: an 8/4 instance for the main
// behaviour plus 16/4 and 6/6 instances for the parameter corner cases.
module tb_seg_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seg_pipe_adder_if #(.WIDTH(8))  bus8 ();
  seg_pipe_adder_if #(.WIDTH(16)) bus16 ();
  seg_pipe_adder_if #(.WIDTH(6))  bus6 ();

  seg_pipe_adder #(.WIDTH(8),  .SEG_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  seg_pipe_adder #(.WIDTH(16), .SEG_W(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  seg_pipe_adder #(.WIDTH(6),  .SEG_W(6)) dut6  (.clk(clk), .rst_n(rst_n), .bus(bus6));

  // Free-running clock.
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic sat);
    bus8.in_valid = 1'b1;
    bus8.a        = a;
    bus8.b        = b;
    bus8.cin      = cin;
    bus8.sat_en   = sat;
  endtask

  task automatic checkOut8(input string tag, input logic v, input logic [8:0] s, input logic h);
    checkOutput({tag, "_valid"}, 32'(bus8.out_valid), 32'(v));
    checkOutput({tag, "_sum"},   32'(bus8.sum),       32'(s));
    checkOutput({tag, "_sat"},   32'(bus8.sat_hit),   32'(h));
  endtask

  task automatic runOne(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sat,
                        input logic [8:0] expSum, input logic expHit);
    applyStimulus(a, b, cin, sat);
    step();
    bus8.in_valid = 1'b0;
    checkOutput({tag, "_early"}, 32'(bus8.out_valid), 32'd0);
    step();
    checkOut8(tag, 1'b1, expSum, expHit);
  endtask

  logic [8:0] got [8];
  int         gotN;
  int         opIdx;
  logic       accepted;

  initial begin
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sat_en  = 1'b0;
    bus8.out_ready = 1'b1;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sat_en = 1'b0;
    bus16.out_ready = 1'b1;
    bus6.in_valid  = 1'b0; bus6.a  = '0; bus6.b  = '0; bus6.cin  = 1'b0; bus6.sat_en  = 1'b0;
    bus6.out_ready = 1'b1;

    // Reset state.
    #2 rst_n = 1'b0;
    #1;
    checkOut8("reset", 1'b0, 9'd0, 1'b0);
    checkOutput("reset_in_ready", 32'(bus8.in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;

    // Sweep a=b=n with full throughput.
    for (int n = 0; n < 16; n++) begin
      applyStimulus(8'(n), 8'(n), 1'b0, 1'b0);
      step();
      if (n == 0) checkOutput("sweep_first_valid", 32'(bus8.out_valid), 32'd0);
      else        checkOut8($sformatf("sweep%0d", n - 1), 1'b1, 9'(2 * (n - 1)), 1'b0);
    end
    bus8.in_valid = 1'b0;
    step();
    checkOut8("sweep15", 1'b1, 9'd30, 1'b0);
    step();
    checkOutput("sweep_drain", 32'(bus8.out_valid), 32'd0);

    // Full carry ripple and saturation modes.
    runOne("carry_raw",  8'hFF, 8'h00, 1'b1, 1'b0, 9'h100, 1'b0);
    runOne("carry_sat",  8'hFF, 8'h00, 1'b1, 1'b1, 9'h0FF, 1'b1);
    runOne("carry_max",  8'hFF, 8'hFF, 1'b1, 1'b0, 9'h1FF, 1'b0);
    runOne("mode_raw",   8'd200, 8'd100, 1'b0, 1'b0, 9'h12C, 1'b0);
    runOne("mode_sat",   8'd200, 8'd100, 1'b0, 1'b1, 9'h0FF, 1'b1);
    runOne("mode_nosat", 8'd100, 8'd100, 1'b0, 1'b1, 9'd200, 1'b0);
    runOne("low_carry",  8'h0F, 8'h01, 1'b0, 1'b0, 9'h010, 1'b0);
    step();

    // Backpressure: four operands offered back to back while the output stalls.
    gotN  = 0;
    opIdx = 0;
    for (int c = 0; c < 14; c++) begin
      bus8.out_ready = (c >= 7);
      if (opIdx < 4) applyStimulus(8'(opIdx + 1), 8'(opIdx + 1), 1'b0, 1'b0);
      else           bus8.in_valid = 1'b0;
      #1;
      if (c >= 2 && c <= 6) begin
        checkOutput($sformatf("bp_in_ready_c%0d", c), 32'(bus8.in_ready), 32'd0);
        checkOutput($sformatf("bp_hold_c%0d", c), 32'(bus8.sum), 32'd2);
        checkOutput($sformatf("bp_valid_c%0d", c), 32'(bus8.out_valid), 32'd1);
      end
      accepted = bus8.in_valid && bus8.in_ready;
      if (bus8.out_valid && bus8.out_ready && gotN < 8) begin
        got[gotN] = bus8.sum;
        gotN++;
      end
      step();
      if (accepted) opIdx++;
    end
    checkOutput("bp_count", 32'(gotN), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("bp_order%0d", i), 32'(got[i]), 32'(2 * (i + 1)));
    bus8.out_ready = 1'b1;

    // Reset while two operations are in flight.
    applyStimulus(8'd3, 8'd3, 1'b0, 1'b0);
    step();
    applyStimulus(8'd5, 8'd5, 1'b0, 1'b0);
    step();
    bus8.in_valid = 1'b0;
    checkOut8("rst_pre", 1'b1, 9'd6, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOut8("rst_now", 1'b0, 9'd0, 1'b0);
    checkOutput("rst_in_ready", 32'(bus8.in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();
    checkOutput("rst_flushed", 32'(bus8.out_valid), 32'd0);
    runOne("rst_after", 8'd7, 8'd9, 1'b0, 1'b0, 9'd16, 1'b0);
    step();
    checkOutput("rst_no_extra", 32'(bus8.out_valid), 32'd0);

    // WIDTH=16, SEG_W=4: latency 4 with a carry through all four segments.
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.cin = 1'b0; bus16.sat_en = 1'b0;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      checkOutput($sformatf("w16_lat%0d", i), 32'(bus16.out_valid), 32'd0);
      step();
    end
    checkOutput("w16_valid", 32'(bus16.out_valid), 32'd1);
    checkOutput("w16_sum", 32'(bus16.sum), 32'h10000);
    checkOutput("w16_sat", 32'(bus16.sat_hit), 32'd0);

    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1; bus16.sat_en = 1'b1;
    bus16.in_valid = 1'b1;
    step();
    bus16.in_valid = 1'b0;
    for (int i = 1; i < 4; i++) step();
    checkOutput("w16s_valid", 32'(bus16.out_valid), 32'd1);
    checkOutput("w16s_sum", 32'(bus16.sum), 32'h0FFFF);
    checkOutput("w16s_sat", 32'(bus16.sat_hit), 32'd1);

    // WIDTH=6, SEG_W=6: single stage, latency 1.
    bus6.a = 6'd63; bus6.b = 6'd63; bus6.cin = 1'b0; bus6.sat_en = 1'b0;
    bus6.in_valid = 1'b1;
    step();
    bus6.in_valid = 1'b0;
    checkOutput("w6_valid", 32'(bus6.out_valid), 32'd1);
    checkOutput("w6_sum", 32'(bus6.sum), 32'd126);
    step();
    checkOutput("w6_drain", 32'(bus6.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
